sc_chain_loader: RTL and testbench

- Configuration-bitstream loader sitting directly upstream of the scan-chain flip-flop column (sc_dff instances).
- Accepts parallel configuration words from a host/bitstream FIFO over a valid/ready handshake.
- Serialises the words LSB-first onto the chain data input.
- Clears the chain before loading, counts exactly CHAIN_LEN shifted bits, then reports done.

---
 rtl/sc_chain_loader_pkg.sv | 25 ++
 rtl/sc_chain_loader_piso.sv | 35 +++
 rtl/sc_chain_loader.sv | 142 ++++++++++++++
 tb/tb_sc_chain_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sc_chain_loader_pkg.sv
// rtl/sc_chain_loader_pkg.sv - shared types and sizing helpers for the scan-chain loader
package sc_chain_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEFAULT_WORD_W = 8;
    localparam int DEFAULT_WBIT_W = $clog2(DEFAULT_WORD_W);

    // Host words needed to cover the chain; unused upper bits of the last word are dropped.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // A 1-bit word still needs a 1-bit in-word position counter.
    function automatic int wbit_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/sc_chain_loader_piso.sv
// rtl/sc_chain_loader_piso.sv - parallel-load, shift-right register feeding the chain LSB-first
module sc_chain_loader_piso #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              dout_lsb
);

    logic [WORD_W-1:0] sreg_q;
    logic [WORD_W-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = sreg_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign dout_lsb = sreg_q[0];

endmodule

// File: rtl/sc_chain_loader.sv
// rtl/sc_chain_loader.sv - serialises host config words into the sc_dff chain (optional SC_CHAIN_LOADER_PARITY_EN)
module sc_chain_loader
    import sc_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              sc_d,
    output logic              sc_shift_en,
    output logic              sc_reset,
    output logic              sc_set,
    output logic              busy,
`ifdef SC_CHAIN_LOADER_PARITY_EN
    input  logic              exp_parity,
    output logic              parity_err,
`endif
    output logic              done
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WBIT_W = wbit_width(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WBIT_W-1:0] LAST_WBIT = WBIT_W'(WORD_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WBIT_W-1:0]  wbit_q, wbit_d;
    logic               done_q, done_d;
    logic               piso_lsb;
    logic               in_fetch, in_shift;
    logic               last_bit;

    assign in_fetch = (state_q == FETCH);
    assign in_shift = (state_q == SHIFT);
    assign last_bit = (bit_cnt_q == LAST_BIT);

    sc_chain_loader_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (in_fetch && word_valid),
        .shift    (in_shift),
        .din      (word_data),
        .dout_lsb (piso_lsb)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        done_d    = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CLEAR;
                    done_d  = 1'b0;
                end
            end
            CLEAR: begin
                bit_cnt_d = '0;
                state_d   = FETCH;
            end
            FETCH: begin
                if (word_valid) begin
                    wbit_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                wbit_d    = wbit_q + WBIT_W'(1);
                // Chain full wins over word exhaustion, so the tail of the last word is discarded.
                if (last_bit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (wbit_q == LAST_WBIT) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            wbit_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            wbit_q    <= wbit_d;
            done_q    <= done_d;
        end
    end

`ifdef SC_CHAIN_LOADER_PARITY_EN
    logic exp_q;
    logic run_xor_q;
    logic parity_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q        <= 1'b0;
            run_xor_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (((state_q == IDLE) || (state_q == DONE)) && start) begin
                exp_q <= exp_parity;
            end
            if (state_q == CLEAR) begin
                run_xor_q    <= 1'b0;
                parity_err_q <= 1'b0;
            end else if (in_shift) begin
                run_xor_q <= run_xor_q ^ piso_lsb;
                if (last_bit) begin
                    parity_err_q <= run_xor_q ^ piso_lsb ^ exp_q;
                end
            end
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign word_ready  = in_fetch;
    assign sc_shift_en = in_shift;
    assign sc_d        = in_shift & piso_lsb;
    assign sc_reset    = (state_q == CLEAR);
    assign sc_set      = 1'b0;
    assign busy        = (state_q == CLEAR) || in_fetch || in_shift;
    assign done        = done_q;

endmodule

// File: tb/tb_sc_chain_loader.sv
// tb/tb_sc_chain_loader.sv - self-checking bench for sc_chain_loader (SC_CHAIN_LOADER_PARITY_EN optional)
module tb_sc_chain_loader;

    localparam int CL = 20;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready, sc_d, sc_shift_en, sc_reset, sc_set, busy, done;
`ifdef SC_CHAIN_LOADER_PARITY_EN
    logic          exp_parity = 1'b0;
    logic          parity_err;
`endif

    int checks = 0;
    int fails  = 0;

    logic [CL-1:0] chain = '0;
    bit            sb_q[$];

    typedef struct {
        logic [WW-1:0] w0, w1, w2;
        int            stall;
        bit            mid_start;
        bit            ep;
        int            exp_lat;
        int            exp_hs;
        int            exp_shifts;
    } vec_t;

    vec_t vecs[6];

    sc_chain_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .sc_d        (sc_d),
        .sc_shift_en (sc_shift_en),
        .sc_reset    (sc_reset),
        .sc_set      (sc_set),
        .busy        (busy),
`ifdef SC_CHAIN_LOADER_PARITY_EN
        .exp_parity  (exp_parity),
        .parity_err  (parity_err),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    // Downstream sc_dff column: cell 0 is the head fed by sc_d.
    always @(posedge clk) begin
        if (sc_reset) chain <= '0;
        else if (sc_shift_en) chain <= {chain[CL-2:0], sc_d};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input vec_t v, input int idx);
        logic [WW-1:0] w[3];
        logic [CL-1:0] exp_chain;
        int lat, hs, nsh, nrst, stall_left;
        bit par, b;
        w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
        lat = -1; hs = 0; nsh = 0; nrst = 0; stall_left = v.stall;
        par = v.ep;
        exp_chain = '0;
        sb_q.delete();
        for (int k = 0; k < CL; k++) begin
            b = w[k / WW][k % WW];
            sb_q.push_back(b);
            exp_chain[CL-1-k] = b;
            par ^= b;
        end
        @(negedge clk);
        start = 1'b1;
        word_valid = 1'b1;
        word_data = w[0];
`ifdef SC_CHAIN_LOADER_PARITY_EN
        exp_parity = v.ep;
`endif
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = v.mid_start && (cyc == 6);
`ifdef SC_CHAIN_LOADER_PARITY_EN
            exp_parity = ~v.ep;
`endif
            if (cyc == 1) begin
                check($sformatf("v%0d_clear_pulse", idx), 32'({sc_reset, busy, done}), 32'b110);
            end
            if (done) begin
                lat = cyc - 1;
                break;
            end
            if (sc_reset) nrst++;
            if (sc_shift_en) begin
                nsh++;
                if (sb_q.size() == 0) check($sformatf("v%0d_extra_shift", idx), 32'(nsh), 32'(CL));
                else check($sformatf("v%0d_sc_d_bit%0d", idx, nsh - 1), 32'(sc_d), 32'(sb_q.pop_front()));
            end
            if (word_ready) begin
                if (hs == 1 && stall_left > 0) begin
                    word_valid = 1'b0;
                    stall_left--;
                    check($sformatf("v%0d_stall_no_shift", idx), 32'(sc_shift_en), 32'd0);
                end else begin
                    word_valid = 1'b1;
                    word_data = (hs < 3) ? w[hs] : '0;
                    hs++;
                end
            end else begin
                word_valid = 1'b1;
            end
        end
        word_valid = 1'b0;
        check($sformatf("v%0d_done_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_handshakes", idx), 32'(hs), 32'(v.exp_hs));
        check($sformatf("v%0d_shift_count", idx), 32'(nsh), 32'(v.exp_shifts));
        check($sformatf("v%0d_sc_reset_cycles", idx), 32'(nrst), 32'd1);
        check($sformatf("v%0d_sb_left", idx), 32'(sb_q.size()), 32'd0);
        check($sformatf("v%0d_chain", idx), 32'(chain), 32'(exp_chain));
        check($sformatf("v%0d_done_outs", idx), 32'({busy, word_ready, sc_shift_en, sc_set}), 32'd0);
`ifdef SC_CHAIN_LOADER_PARITY_EN
        check($sformatf("v%0d_parity_err", idx), 32'(parity_err), 32'(par));
`endif
        sb_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'hF9, 0, 1'b0, 1'b1, 24, 3, 20};
        vecs[1] = '{8'hA5, 8'h3C, 8'hF9, 5, 1'b0, 1'b1, 29, 3, 20};
        vecs[2] = '{8'hA5, 8'h3C, 8'hF9, 0, 1'b1, 1'b0, 24, 3, 20};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 24, 3, 20};
        vecs[4] = '{8'hFF, 8'h00, 8'h5A, 0, 1'b0, 1'b1, 24, 3, 20};
        vecs[5] = '{8'h6B, 8'hD2, 8'h07, 2, 1'b1, 1'b0, 26, 3, 20};

        #12;
        check("reset_outs", 32'({word_ready, sc_d, sc_shift_en, sc_reset, sc_set, busy, done}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_outs", 32'({word_ready, sc_shift_en, sc_reset, busy, done}), 32'd0);
`ifdef SC_CHAIN_LOADER_PARITY_EN
        check("idle_parity_err", 32'(parity_err), 32'd0);
`endif

        for (int i = 0; i < 6; i++) run_load(vecs[i], i);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        start = 1'b1;
        word_valid = 1'b1;
        word_data = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_in_shift", 32'({sc_shift_en, busy, done}), 32'b110);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outs", 32'({word_ready, sc_d, sc_shift_en, sc_reset, sc_set, busy, done}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        word_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'({word_ready, sc_shift_en, sc_reset, busy, done}), 32'd0);
`ifdef SC_CHAIN_LOADER_PARITY_EN
        check("post_reset_parity_err", 32'(parity_err), 32'd0);
`endif

        run_load(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
